// File: rtl/usb_buf_pkg.sv
// Shared types and default sizes for the USB byte FIFO between the AHB slave and packet engines.
package usb_buf_pkg;

    localparam int DEPTH_DEFAULT  = 64;
    localparam int ADDR_W_DEFAULT = 6;
    localparam int OCC_W          = 7;
    localparam int BYTE_W         = 8;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [OCC_W-1:0]  occ_t;

endpackage : usb_buf_pkg

// File: rtl/usb_buf_ram.sv
// DEPTH x 8 storage array: synchronous write port, combinational (fall-through) read port.
module usb_buf_ram
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  byte_t             wdata,
    input  logic [ADDR_W-1:0] raddr,
    output byte_t             rdata
);

    byte_t mem_q [DEPTH];

    // NOTE: the array has no reset; pointers and count define validity, and leaving it
    // unreset lets it map onto plain RAM instead of thousands of resettable flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : usb_buf_ram

// File: rtl/usb_data_buffer.sv
// Shared 64-byte FIFO between the AHB slave and the USB RX/TX engines.
// Define USB_BUF_STICKY_ERR_EN to make buf_err hold until clear or rst.
module usb_data_buffer
    import usb_buf_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  clear,
    input  logic  store_tx_data,
    input  byte_t tx_data,
    input  logic  get_rx_data,
    output byte_t rx_data,
    input  logic  store_rx_packet_data,
    input  byte_t rx_packet_data,
    input  logic  get_tx_packet_data,
    output byte_t tx_packet_data,
    output occ_t  buffer_occupancy,
    output logic  full,
    output logic  empty,
    output logic  buf_err
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;

    logic  push_req, pop_req, conflict;
    logic  push_ok, pop_ok, err_evt;
    logic  is_full, is_empty;
    byte_t push_byte;
    byte_t head_byte;

    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);

    // The RX engine wins a simultaneous store; the AHB byte is dropped and flagged.
    assign conflict  = store_rx_packet_data & store_tx_data;
    assign push_req  = store_rx_packet_data | store_tx_data;
    assign push_byte = store_rx_packet_data ? rx_packet_data : tx_data;
    assign pop_req   = get_rx_data | get_tx_packet_data;

    // A pop on a full buffer frees the slot the simultaneous push reuses.
    assign pop_ok   = pop_req & ~is_empty & ~clear;
    assign push_ok  = push_req & (~is_full | pop_req) & ~clear;
    assign err_evt  = conflict | (push_req & is_full & ~pop_req) | (pop_req & is_empty);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = 1'b0;

        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop_ok) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
`ifdef USB_BUF_STICKY_ERR_EN
            err_d = err_q | err_evt;
`else
            err_d = err_evt;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    usb_buf_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wptr_q),
        .wdata (push_byte),
        .raddr (rptr_q),
        .rdata (head_byte)
    );

    assign rx_data          = head_byte;
    assign tx_packet_data   = head_byte;
    assign buffer_occupancy = OCC_W'(count_q);
    assign full             = is_full;
    assign empty            = is_empty;
    assign buf_err          = err_q;

endmodule : usb_data_buffer

// File: tb/tb_usb_data_buffer.sv
// Table-driven bench for usb_data_buffer; expectations follow the FIFO contract, sticky mode tracked.
module tb_usb_data_buffer;
    import usb_buf_pkg::*;

`ifdef USB_BUF_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  clear = 1'b0;
    logic  store_tx_data = 1'b0;
    byte_t tx_data = '0;
    logic  get_rx_data = 1'b0;
    byte_t rx_data;
    logic  store_rx_packet_data = 1'b0;
    byte_t rx_packet_data = '0;
    logic  get_tx_packet_data = 1'b0;
    byte_t tx_packet_data;
    occ_t  buffer_occupancy;
    logic  full, empty, buf_err;

    always #5 clk = ~clk;

    usb_data_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .rx_data              (rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .tx_packet_data       (tx_packet_data),
        .buffer_occupancy     (buffer_occupancy),
        .full                 (full),
        .empty                (empty),
        .buf_err              (buf_err)
    );

    // One cycle of stimulus plus the state expected just after the edge.
    // err is the per-cycle error event; sticky expectations are derived from it.
    typedef struct {
        logic  rst;
        logic  clr;
        logic  stx;
        byte_t txd;
        logic  srx;
        byte_t rxd;
        logic  grx;
        logic  gtx;
        int    occ;
        logic  err;
        logic  chk_head;
        byte_t head;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic err_flag = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic stx, input byte_t txd,
                                input logic srx, input byte_t rxd, input logic grx,
                                input logic gtx, input int occ, input logic err,
                                input logic chk_head, input byte_t head);
        vec_t v;
        v.rst = 1'b0;  v.clr = clr;  v.stx = stx;  v.txd = txd;
        v.srx = srx;   v.rxd = rxd;  v.grx = grx;  v.gtx = gtx;
        v.occ = occ;   v.err = err;  v.chk_head = chk_head;  v.head = head;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic exp_err;
        rst                  = v.rst;
        clear                = v.clr;
        store_tx_data        = v.stx;
        tx_data              = v.txd;
        store_rx_packet_data = v.srx;
        rx_packet_data       = v.rxd;
        get_rx_data          = v.grx;
        get_tx_packet_data   = v.gtx;
        @(posedge clk);
        #1;
        rst                  = 1'b0;
        clear                = 1'b0;
        store_tx_data        = 1'b0;
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        get_tx_packet_data   = 1'b0;
        if (v.rst || v.clr) err_flag = 1'b0;
        else                err_flag = err_flag | v.err;
        exp_err = STICKY ? err_flag : v.err;
        check({tag, " occ"},   32'(buffer_occupancy), 32'(v.occ));
        check({tag, " empty"}, 32'(empty),            32'(v.occ == 0));
        check({tag, " full"},  32'(full),             32'(v.occ == 64));
        check({tag, " err"},   32'(buf_err),          32'(exp_err));
        if (v.chk_head) begin
            check({tag, " rx_data"},        32'(rx_data),        32'(v.head));
            check({tag, " tx_packet_data"}, 32'(tx_packet_data), 32'(v.head));
        end
    endtask

    vec_t vecs[13];
    vec_t v;

    initial begin
        //              clr stx txd    srx rxd    grx gtx occ err chk head
        vecs[0]  = mk(0, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 0, 1, 8'hA5);  // AHB push
        vecs[1]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00);  // TX pop
        vecs[2]  = mk(0, 1, 8'h11, 1, 8'h22, 0, 0, 1, 1, 1, 8'h22);  // write conflict
        vecs[3]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        vecs[4]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00);  // underflow
        vecs[5]  = mk(0, 0, 8'h00, 1, 8'h33, 0, 1, 1, 1, 1, 8'h33);  // empty push+pop
        vecs[6]  = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1, 8'h33);
        vecs[7]  = mk(0, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00);  // dual pop = one pop
        vecs[8]  = mk(0, 1, 8'h44, 0, 8'h00, 0, 0, 1, 0, 1, 8'h44);
        vecs[9]  = mk(0, 0, 8'h00, 1, 8'h55, 0, 0, 2, 0, 1, 8'h44);
        vecs[10] = mk(0, 1, 8'h66, 0, 8'h00, 0, 1, 2, 0, 1, 8'h55);  // push+pop mid
        vecs[11] = mk(1, 0, 8'h00, 1, 8'h99, 1, 0, 0, 0, 0, 8'h00);  // clear beats push/pop
        vecs[12] = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);

        // Reset held for two cycles, then idle.
        v = mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        v.rst = 1'b1;
        apply(v, "reset0");
        apply(v, "reset1");
        v.rst = 1'b0;
        apply(v, "idle");

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i], $sformatf("vec[%0d]", i));
        end

        // Fill to 64 through the RX engine, then overflow.
        for (int i = 0; i < 64; i++) begin
            apply(mk(0, 0, 8'h00, 1, byte_t'(i), 0, 0, i + 1, 0, 1, 8'h00), $sformatf("fill[%0d]", i));
        end
        apply(mk(0, 1, 8'hEE, 0, 8'h00, 0, 0, 64, 1, 1, 8'h00), "overflow");

        // Drain through the AHB side; pointers wrap along the way.
        for (int i = 0; i < 64; i++) begin
            apply(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 63 - i, 0, (i < 63), byte_t'(i + 1)),
                  $sformatf("drain[%0d]", i));
        end

        // Full buffer with simultaneous push and pop.
        apply(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00), "clear_pre_full");
        for (int i = 0; i < 64; i++) begin
            apply(mk(0, 1, byte_t'(8'h80 + i), 0, 8'h00, 0, 0, i + 1, 0, 1, 8'h80),
                  $sformatf("refill[%0d]", i));
        end
        apply(mk(0, 1, 8'h77, 0, 8'h00, 0, 1, 64, 0, 1, 8'h81), "full_push_pop");
        for (int j = 0; j < 63; j++) begin
            apply(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 63 - j, 0, 1,
                     (j < 62) ? byte_t'(8'h82 + j) : 8'h77), $sformatf("drain2[%0d]", j));
        end
        apply(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00), "drain2_last");

        // Error event, fill 10, then clear with a concurrent push.
        apply(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 8'h00), "underflow2");
        for (int i = 0; i < 10; i++) begin
            apply(mk(0, 1, byte_t'(8'h10 + i), 0, 8'h00, 0, 0, i + 1, 0, 1, 8'h10),
                  $sformatf("fill10[%0d]", i));
        end
        apply(mk(1, 1, 8'hAB, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00), "clear_with_push");
        apply(mk(0, 1, 8'hCD, 0, 8'h00, 0, 0, 1, 0, 1, 8'hCD), "after_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_usb_data_buffer
